// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Widest value twos_neg can handle; callers cast the result back to their width.
  localparam int unsigned NEG_MAX_W = 256;

  function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v);
    return ~v + NEG_MAX_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude on operand entry, sign restore on results.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? W'(twos_neg(NEG_MAX_W'(value))) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with start/busy/done handshake.
// Optional: MULDIV_EARLY_TERM_EN ends a multiply once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             div_by_zero
);

  state_t             state;
  logic               op_r;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   opnd;
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   mplier;
`endif

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .value (A),
    .negate(signed_op & A[WIDTH-1]),
    .result(a_mag)
  );

  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .value (B),
    .negate(signed_op & B[WIDTH-1]),
    .result(b_mag)
  );

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .value (prod_raw),
    .negate(neg_q),
    .result(prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .value (lo),
    .negate(neg_q),
    .result(quo_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .value (hi),
    .negate(neg_r),
    .result(rem_fix)
  );

  // Multiply: {hi,lo} is the accumulator with the multiplier draining out of lo.
  // Divide: hi is the remainder, lo shifts dividend bits out and quotient bits in;
  // the W+1-bit partial remainder only ever exists as div_shift.
  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
`ifdef MULDIV_EARLY_TERM_EN
    prod_raw  = {hi, lo} >> cnt;
`else
    prod_raw  = {hi, lo};
`endif
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      op_r        <= OP_MUL;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
`ifdef MULDIV_EARLY_TERM_EN
      mplier      <= '0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      z_high      <= '0;
      z_low       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            neg_q       <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r       <= signed_op & A[WIDTH-1];
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (op == OP_DIV && B == '0) begin
              // One dwell cycle in FIX keeps the div-by-zero latency at two edges.
              dz    <= 1'b1;
              hi    <= A;
              lo    <= '1;
              cnt   <= CNT_W'(1);
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              hi    <= '0;
              lo    <= (op == OP_MUL) ? b_mag : a_mag;
              opnd  <= (op == OP_MUL) ? a_mag : b_mag;
              cnt   <= CNT_W'(WIDTH);
`ifdef MULDIV_EARLY_TERM_EN
              mplier <= b_mag;
`endif
              state <= CALC;
            end
          end
        end

        CALC: begin
`ifdef MULDIV_EARLY_TERM_EN
          // Early exit leaves cnt at the remaining count; FIX realigns by that amount.
          if (op_r == OP_MUL && mplier == '0) begin
            state <= FIX;
          end else begin
`endif
            if (op_r == OP_MUL) begin
              hi <= mul_sum[WIDTH:1];
              lo <= {mul_sum[0], lo[WIDTH-1:1]};
`ifdef MULDIV_EARLY_TERM_EN
              mplier <= mplier >> 1;
`endif
            end else begin
              hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], div_ge};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
`ifdef MULDIV_EARLY_TERM_EN
          end
`endif
        end

        FIX: begin
          if (dz && cnt != '0) begin
            cnt <= '0;
          end else begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= dz;
            if (dz) begin
              z_high <= hi;
              z_low  <= lo;
            end else if (op_r == OP_MUL) begin
              {z_high, z_low} <= prod_fix;
            end else begin
              z_high <= rem_fix;
              z_low  <= quo_fix;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven checks for muldiv_unit at WIDTH=32 (default build).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic          Clock = 1'b0;
  logic          clear;
  logic          start;
  logic          op;
  logic          signed_op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [W-1:0]  z_high;
  logic [W-1:0]  z_low;
  logic          div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .clear      (clear),
    .start      (start),
    .op         (op),
    .signed_op  (signed_op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .z_high     (z_high),
    .z_low      (z_low),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    string        name;
    logic         op;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Accepting edge is edge 0; returns once done has been observed (or budget expires).
  task automatic accept(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string nm);
    @(negedge Clock);
    op = o; signed_op = s; A = a; B = b; start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; op = 1'($urandom); signed_op = 1'($urandom);
    chk({nm, ":busy_after_accept"}, 64'(busy), 64'd1);
    chk({nm, ":dz_cleared_on_accept"}, 64'(div_by_zero), 64'd0);
  endtask

  task automatic wait_done(input int pulse_at, output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      @(posedge Clock);
      n++;
      #1;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      start = (pulse_at != 0) && (n == pulse_at || n == pulse_at + 1);
      if (start) begin
        op = OP_MUL; signed_op = 1'b0; A = 32'd3; B = 32'd4;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input int n, input logic busy_ok);
    chk({v.name, ":latency"}, 64'(n), 64'(v.lat));
    chk({v.name, ":busy_until_done"}, 64'(busy_ok), 64'd1);
    chk({v.name, ":z_high"}, 64'(z_high), 64'(v.hi));
    chk({v.name, ":z_low"}, 64'(z_low), 64'(v.lo));
    chk({v.name, ":div_by_zero"}, 64'(div_by_zero), 64'(v.dz));
    chk({v.name, ":busy_at_done"}, 64'(busy), 64'd0);
    @(posedge Clock);
    #1;
    chk({v.name, ":done_one_cycle"}, 64'(done), 64'd0);
    chk({v.name, ":z_low_held"}, 64'(z_low), 64'(v.lo));
  endtask

  task automatic run_vec(input vec_t v, input int pulse_at);
    int   n;
    logic bok;
    accept(v.op, v.sg, v.a, v.b, v.name);
    wait_done(pulse_at, n, bok);
    check_result(v, n, bok);
  endtask

  initial begin
    int   n;
    logic bok;
    logic saw_done;

    tbl[0]  = '{"umul_max",   OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    tbl[1]  = '{"smul_m7x3",  OP_MUL, 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    tbl[2]  = '{"sdiv_m7d2",  OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    tbl[3]  = '{"udiv_7d2",   OP_DIV, 1'b0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 33};
    tbl[4]  = '{"udiv_5d0",   OP_DIV, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 2};
    tbl[5]  = '{"sdiv_min",   OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    tbl[6]  = '{"umul_shift", OP_MUL, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 33};
    tbl[7]  = '{"sdiv_7dm2",  OP_DIV, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
    tbl[8]  = '{"sdiv_m5d0",  OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2};
    tbl[9]  = '{"smul_m1xm1", OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    tbl[10] = '{"udiv_100d7", OP_DIV, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};

    clear = 1'b0; start = 1'b0; op = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:z_high", 64'(z_high), 64'd0);
    chk("reset:z_low", 64'(z_low), 64'd0);
    chk("reset:div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge Clock);
    clear = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], 0);

    // start re-pulsed on edges 5 and 6 of CALC must not disturb the running multiply
    run_vec(tbl[0], 5);

    // asynchronous abort on the 10th edge of CALC
    accept(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, "abort");
    repeat (10) @(posedge Clock);
    #2;
    clear = 1'b0;
    #1;
    chk("abort:busy", 64'(busy), 64'd0);
    chk("abort:done", 64'(done), 64'd0);
    chk("abort:z_high", 64'(z_high), 64'd0);
    chk("abort:z_low", 64'(z_low), 64'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge Clock);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge Clock);
    clear = 1'b1;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort:no_done_or_busy_after", 64'(saw_done), 64'd0);
    run_vec(tbl[3], 0);

    // start held through DONE is ignored; it is taken at the following IDLE edge
    accept(OP_DIV, 1'b0, 32'd7, 32'd2, "done_start");
    wait_done(0, n, bok);
    chk("done_start:latency", 64'(n), 64'd33);
    op = OP_DIV; signed_op = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge Clock);
    #1;
    chk("done_start:ignored_in_done", 64'(busy), 64'd0);
    chk("done_start:z_low_kept", 64'(z_low), 64'd3);
    @(posedge Clock);
    #1;
    chk("done_start:accepted_in_idle", 64'(busy), 64'd1);
    start = 1'b0;
    A = $urandom; B = $urandom;
    wait_done(0, n, bok);
    check_result(tbl[10], n, bok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
